// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// One byte in flight at a time; WAIT is bounded by a timeout and aborted by dropping uart_en.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TO_W    = 20,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 uart_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 timeout_err,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 start_tx,
  output logic [7:0]           data_in,
  input  logic                 tx_done
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [7:0]       data_q;
  logic [TO_W-1:0]  timer_q;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] grant_next;
  logic             found;
  logic             timer_limit;
  logic             done_fire;
  logic             to_fire;

  // First set request at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin : rr_search
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    winner   = rr_ptr_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  assign grant_next  = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  assign timer_limit = (timer_q == TO_W'(TIMEOUT - 1));

  // tx_done beats the timeout limit; reset and a dropped enable suppress both pulses.
  assign done_fire = (state_q == StWait) && uart_en && !reset && tx_done;
  assign to_fire   = (state_q == StWait) && uart_en && !reset && !tx_done && timer_limit;

  always_comb begin
    ack = '0;
    if (done_fire) begin
      ack[grant_idx_q] = 1'b1;
    end
  end

  assign timeout_err = to_fire;
  assign start_tx    = (state_q == StLaunch) && uart_en && !reset;
  assign busy        = (state_q != StIdle);
  assign grant_idx   = grant_idx_q;
  assign data_in     = data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      data_q      <= 8'h00;
      timer_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (uart_en && found) begin
            grant_idx_q <= winner;
            data_q      <= req_data[{winner, 3'b000} +: 8];
            state_q     <= StLaunch;
          end
        end
        StLaunch: begin
          if (!uart_en) begin
            state_q <= StIdle;
          end else begin
            timer_q <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!uart_en) begin
            state_q <= StIdle;
          end else if (tx_done || timer_limit) begin
            rr_ptr_q <= grant_next;
            state_q  <= StIdle;
          end else begin
            timer_q <= timer_q + TO_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter: stimulus queues expected launches and
// completions from a transfer-level model; a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        uart_en = 1'b0;
  logic        tx_done = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  ack;
  logic        timeout_err;
  logic        busy;
  logic [1:0]  grant_idx;
  logic        start_tx;
  logic [7:0]  data_in;

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .IDX_W   (2),
    .TO_W    (20),
    .TIMEOUT (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .uart_en     (uart_en),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .timeout_err (timeout_err),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .start_tx    (start_tx),
    .data_in     (data_in),
    .tx_done     (tx_done)
  );

  always #5 clock = ~clock;

  int cyc_n = 0;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  typedef struct {int cyc; int idx; int data; bit fire;} launch_t;
  // kind: 0 = ack, 1 = timeout_err, 2 = abort (neither pulse)
  typedef struct {int cyc; int kind; int idx;} done_t;

  launch_t lq[$];
  done_t   cq[$];
  int      total = 0;
  int      bad = 0;
  bit      mon_en = 1'b0;
  int      busy_chk = -1;
  int      rr_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got 'h%0h, expected 'h%0h", name, cyc_n, act, exp);
    end
  endtask

  // Winner = first set bit when the request vector is rotated to start at the pointer.
  function automatic int pick(input int rr, input logic [3:0] p);
    logic [7:0] dbl;
    dbl = {p, p} >> rr;
    for (int j = 0; j < N; j++) begin
      if (dbl[j]) return (rr + j) % N;
    end
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    launch_t le;
    done_t   de;
    if (mon_en) begin
      if (lq.size() > 0 && lq[0].cyc == cyc_n) begin
        le = lq.pop_front();
        chk("start_tx", 32'(start_tx), 32'(le.fire));
        if (le.fire) begin
          chk("grant_idx", 32'(grant_idx), le.idx);
          chk("data_in", 32'(data_in), le.data);
          chk("busy_launch", 32'(busy), 1);
        end
      end else begin
        chk("spurious_start", 32'(start_tx), 0);
      end
      if (cq.size() > 0 && cq[0].cyc == cyc_n) begin
        de = cq.pop_front();
        chk("ack", 32'(ack), (de.kind == 0) ? (32'd1 << de.idx) : 32'd0);
        chk("timeout_err", 32'(timeout_err), (de.kind == 1) ? 1 : 0);
        busy_chk = cyc_n + 1;
      end else begin
        chk("spurious_ack", 32'(ack), 0);
        chk("spurious_err", 32'(timeout_err), 0);
      end
      if (busy_chk == cyc_n) chk("busy_fall", 32'(busy), 0);
    end
  end

  task automatic do_reset(input logic pulse_done);
    reset   = 1'b1;
    tx_done = pulse_done;
    cyc();
    tx_done = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_idx), 0);
    chk("rst_data", 32'(data_in), 0);
    chk("rst_start", 32'(start_tx), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(timeout_err), 0);
    cyc();
    reset = 1'b0;
    rr_m  = 0;
  endtask

  // scen: 0 done after r, 1 timeout, 2 uart_en drop in WAIT, 3 drop in LAUNCH,
  //       4 done on the timeout cycle, 5 reset in WAIT
  task automatic xfer(input logic [3:0] pat, input logic [31:0] dat, input int scen, input int r);
    int      k;
    int      g;
    launch_t le;
    done_t   de;
    uart_en  = 1'b1;
    req      = pat;
    req_data = dat;
    tx_done  = 1'b0;
    k = cyc_n;
    g = pick(rr_m, pat);
    le.cyc  = k + 1;
    le.idx  = g;
    le.data = int'((dat >> (8 * g)) & 32'hFF);
    le.fire = (scen != 3);
    lq.push_back(le);
    de.idx  = g;
    de.kind = 2;
    case (scen)
      0:       begin de.kind = 0; de.cyc = k + 2 + r; end
      4:       begin de.kind = 0; de.cyc = k + 2 + TO - 1; end
      1:       begin de.kind = 1; de.cyc = k + 2 + TO - 1; end
      2, 5:    de.cyc = k + 2 + r;
      default: de.cyc = k + 1;
    endcase
    cq.push_back(de);
    cyc();
    if (scen == 3) begin
      uart_en = 1'b0;
      cyc();
      cyc();
      return;
    end
    // Post-grant changes must not disturb the byte in flight; tx_done in LAUNCH is ignored.
    if ($urandom_range(3) == 0) begin
      req      = 4'($urandom);
      req_data = $urandom;
    end
    tx_done = 1'($urandom_range(1));
    cyc();
    tx_done = 1'b0;
    while (cyc_n < de.cyc) cyc();
    case (scen)
      0, 4: begin
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        rr_m = (g + 1) % N;
      end
      1: begin
        cyc();
        rr_m = (g + 1) % N;
      end
      2: begin
        uart_en = 1'b0;
        tx_done = 1'($urandom_range(1));
        cyc();
        tx_done = 1'b0;
        cyc();
      end
      default: do_reset(1'b1);
    endcase
  endtask

  initial begin
    logic [3:0]  pat;
    logic [31:0] dat;
    int          v;
    int          scen;
    do_reset(1'b0);
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) xfer(4'hF, 32'h4433_2211, 0, 3 + i);
    xfer(4'b0100, 32'h00A5_0000, 0, 10);
    xfer(4'b0010, 32'h0000_5A00, 1, 0);
    xfer(4'b0010, 32'h0000_5A00, 0, 2);
    xfer(4'b1010, 32'hC300_3C00, 2, 5);
    xfer(4'b1010, 32'hC300_3C00, 0, 1);
    xfer(4'b0110, 32'h0077_6600, 5, 4);
    xfer(4'b1100, 32'hEEDD_0000, 0, 0);
    xfer(4'b0001, 32'h0000_0099, 4, 0);
    pat = 4'h1;
    dat = 32'h0;
    for (int n = 0; n < 300; n++) begin
      if (n == 0 || $urandom_range(1) == 0) begin
        pat = 4'($urandom_range(1, 15));
        dat = $urandom;
      end
      v = int'($urandom_range(0, 9));
      scen = (v < 5) ? 0 : v - 4;
      xfer(pat, dat, scen, int'($urandom_range(0, TO - 1)));
      if ($urandom_range(3) == 0) begin
        uart_en = 1'($urandom_range(1));
        req     = uart_en ? 4'h0 : 4'($urandom);
        tx_done = 1'($urandom_range(1));
        repeat ($urandom_range(1, 3)) cyc();
        tx_done = 1'b0;
      end
    end
    cyc();
    chk("queue_drain", 32'(lq.size() + cq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: got no completion, expected run end before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
